regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with an integrated write-pending scoreboard, optional same-cycle write-to-read bypass and a sequential clear engine. It replaces the fixed 4x8, two-read-port register file in the datapath. It generalises width, depth and read-port count. It adds per-register hazard flags for the issue stage and a multi-cycle clear used on context switch.

## Interface
- WIDTH, 8, data width of each register
- DEPTH, 4, number of registers (>=2); AW = $clog2(DEPTH)
- RD_PORTS, 2, number of independent combinational read ports (>=1)
- TAP_REG, 1, index of register exposed on tap_data (< DEPTH)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- ZERO_REG0, 0, 1 = register 0 hard-wired to zero, writes/issues to it dropped

Ports (clock and reset first):
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  reset, asynchronous, active-high
- rd_addr  input  RD_PORTS*AW  read addresses, port i in bits [i*AW +: AW]
- rd_data  output  RD_PORTS*WIDTH  read data, port i in bits [i*WIDTH +: WIDTH]
- rd_busy  output  RD_PORTS  pending flag of the register addressed by port i
- wr_en  input  1  write strobe
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- issue_en  input  1  mark issue_addr as having an outstanding producer
- issue_addr  input  AW  register being marked pending
- clear_req  input  1  start a sequential clear of all registers
- clear_busy  output  1  high while the clear engine is running
- pending_any  output  1  OR of all pending bits
- tap_data  output  WIDTH  stored contents of register TAP_REG; never bypassed

## Operation
- State: regs[DEPTH] of WIDTH bits, pending[DEPTH] bits, FSM {IDLE, CLEAR}, clear index idx (AW bits).
- Reset: all regs = 0, all pending = 0, FSM = IDLE, idx = 0.
  - Outputs during reset: rd_data = 0, rd_busy = 0, clear_busy = 0, pending_any = 0, tap_data = 0.
- Write (IDLE only): wr_en writes regs[wr_addr] <= wr_data and clears pending[wr_addr].
- Addresses >= DEPTH:
  - Writes and issues to such an address are dropped.
  - Reads from such an address return 0 and rd_busy = 0.
- Read: rd_data[i] = regs[rd_addr[i]], combinational.
  - BYPASS=1, IDLE, wr_en and wr_addr == rd_addr[i] (valid, not dropped): rd_data[i] = wr_data and rd_busy[i] = 0 in the same cycle.
  - BYPASS=0: a read returns the old value until the edge.
- rd_busy[i] = pending[rd_addr[i]], subject to the bypass override above.
- Issue (IDLE only): issue_en sets pending[issue_addr].
  - If issue and write hit the same address in the same cycle, the stored data takes wr_data and pending ends 1 (new producer wins).
- ZERO_REG0=1: register 0 reads 0 and is never pending; writes and issues to it are ignored.
- Clear FSM:
  - IDLE -> CLEAR when clear_req = 1 at an edge; idx <= 0.
  - In CLEAR, each edge does regs[idx] <= 0, pending[idx] <= 0, idx <= idx+1.
  - When the edge clears idx == DEPTH-1, the FSM returns to IDLE.
  - While in CLEAR: wr_en and issue_en are ignored (caller stalls on clear_busy), clear_req is ignored, bypass is disabled, and reads return current stored contents.
- A clear_req edge coincident with wr_en/issue_en in IDLE: that write/issue is still performed, then clearing starts next edge.
- Reset asserted mid-clear aborts the clear immediately; state becomes the reset state.

## Timing
- Write latency: 1 edge to storage and tap_data; 0 cycles to matching read ports when BYPASS=1.
- Issue-to-rd_busy latency: 1 edge.
- Write-to-rd_busy clear: 0 cycles with BYPASS=1, 1 edge with BYPASS=0.
- Clear: clear_req sampled at edge k; clear_busy high from edge k to edge k+DEPTH (exactly DEPTH cycles); register j reads 0 after edge k+1+j.
- All outputs are combinational from state and current inputs; there are no registered outputs besides storage.

## Test plan
- Reset, then write 0xA5 to r2 and 0x3C to r1 in consecutive cycles -> rd_addr = {2,1} reads {0xA5, 0x3C}; tap_data = 0x3C one edge after its write.
- BYPASS=1: write 0x77 to r3 while port 0 reads r3 -> rd_data[0] = 0x77 in the same cycle. BYPASS=0 instance: reads the old value, then 0x77 after the edge.
- Issue r2 -> rd_busy for r2 = 1 and pending_any = 1 next cycle. Write r2 = 0x11 -> rd_busy drops (same cycle with bypass) and pending_any = 0 after the edge. Simultaneous issue and write to r1 -> r1 = data and r1 still pending.
- Fill all regs with 0xFF and issue all, pulse clear_req -> clear_busy high for exactly DEPTH cycles; r0..r3 read 0 on successive cycles; writes during CLEAR have no effect; pending_any = 0 at the end.
- ZERO_REG0=1, WIDTH=16, DEPTH=8, RD_PORTS=3: write 0xBEEF to r0 and 0x1234 to r7, issue r0 -> r0 reads 0 and not busy; r7 reads 0x1234 on all three ports.
- Assert reset mid-clear (idx = 2) with pending bits set -> all outputs 0 immediately; FSM in IDLE; next write lands normally.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle between the issue/datapath logic and regfile_sb.
// Ports carried:
//   rd_addr/rd_data/rd_busy    RD_PORTS packed read ports (port i in slice i)
//   wr_en/wr_addr/wr_data      single write port
//   issue_en/issue_addr        marks a register as having an outstanding producer
//   clear_req/clear_busy       sequential clear handshake
//   pending_any                OR of all pending flags
//   tap_data                   stored contents of the tap register
// The master modport is the requester side; the slave modport is the register file.
interface regfile_sb_if #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int RD_PORTS = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [RD_PORTS*AW-1:0]    rd_addr;
  logic [RD_PORTS*WIDTH-1:0] rd_data;
  logic [RD_PORTS-1:0]       rd_busy;
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic                      issue_en;
  logic [AW-1:0]             issue_addr;
  logic                      clear_req;
  logic                      clear_busy;
  logic                      pending_any;
  logic [WIDTH-1:0]          tap_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, clear_req,
    input  rd_data, rd_busy, clear_busy, pending_any, tap_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, clear_req,
    output rd_data, rd_busy, clear_busy, pending_any, tap_data
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register write-pending
// scoreboard, optional same-cycle write-to-read bypass and a sequential clear
// engine that zeroes one register per clock.
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous, active-high; zeroes storage, pending flags and the FSM
//   bus    regfile_sb_if.slave carrying the read, write, issue and clear signals
module regfile_sb #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int RD_PORTS  = 2,
  parameter int TAP_REG   = 1,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] TAP_IDX = AW'(TAP_REG);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [AW-1:0]    idx;
  logic             wr_ok;
  logic             issue_ok;
  logic             bypass_ok;
  logic [AW-1:0]    rd_addr_arr [RD_PORTS];

  // An address is usable when it names a real register and is not the
  // hard-wired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG0 && (a == '0));
  endfunction

  // Writes and issues only act in IDLE; the clear engine owns storage otherwise.
  // Bypass is also masked during reset so all read ports show zero then.
  always_comb begin
    wr_ok     = bus.wr_en && (state == IDLE) && addr_live(bus.wr_addr);
    issue_ok  = bus.issue_en && (state == IDLE) && addr_live(bus.issue_addr);
    bypass_ok = BYPASS && wr_ok && !reset;
  end

  // Unpack the flat read-address bus into one address per port.
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd_addr
    assign rd_addr_arr[i] = bus.rd_addr[i*AW +: AW];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: a clear request in IDLE starts the sweep, and the sweep
  // ends on the edge that clears the last register.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.clear_req) state_next = CLEAR;
      CLEAR:   if (idx == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear index: parked at zero in IDLE so a new sweep always starts at r0,
  // and wrapped explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               idx <= '0;
    else if (state == IDLE || idx == LAST)   idx <= '0;
    else                                     idx <= idx + 1'b1;
  end

  // Storage and scoreboard. The issue update is placed after the write so
  // that a same-address issue and write leaves the register pending: the new
  // producer wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
      pending <= '0;
    end else if (state == CLEAR) begin
      regs[idx]    <= '0;
      pending[idx] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[bus.wr_addr]    <= bus.wr_data;
        pending[bus.wr_addr] <= 1'b0;
      end
      if (issue_ok) pending[bus.issue_addr] <= 1'b1;
    end
  end

  // Read ports: dead addresses read zero and not busy; a matching bypassed
  // write supplies the data and hides the pending flag it is about to clear.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      if (addr_live(rd_addr_arr[i])) begin
        if (bypass_ok && (bus.wr_addr == rd_addr_arr[i])) begin
          bus.rd_data[i*WIDTH +: WIDTH] = bus.wr_data;
        end else begin
          bus.rd_data[i*WIDTH +: WIDTH] = regs[rd_addr_arr[i]];
          bus.rd_busy[i]                = pending[rd_addr_arr[i]];
        end
      end
    end
  end

  // Status outputs; the tap always shows stored contents, never bypass data.
  always_comb begin
    bus.clear_busy  = (state == CLEAR);
    bus.pending_any = |pending;
    bus.tap_data    = regs[TAP_IDX];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb.
// Three instances: A (default 4x8, bypass on), B (bypass off) and
// C (16-bit, 8 regs, 3 read ports, r0 hard-wired to zero).
module tb_regfile_sb;
  logic clk;
  logic reset;
  int   pass_count  = 0;
  int   check_count = 0;

  regfile_sb_if #(.WIDTH(8),  .DEPTH(4), .RD_PORTS(2)) a_if();
  regfile_sb_if #(.WIDTH(8),  .DEPTH(4), .RD_PORTS(2)) b_if();
  regfile_sb_if #(.WIDTH(16), .DEPTH(8), .RD_PORTS(3)) c_if();

  regfile_sb #(.WIDTH(8), .DEPTH(4), .RD_PORTS(2), .TAP_REG(1),
               .BYPASS(1'b1), .ZERO_REG0(1'b0))
    dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));

  regfile_sb #(.WIDTH(8), .DEPTH(4), .RD_PORTS(2), .TAP_REG(1),
               .BYPASS(1'b0), .ZERO_REG0(1'b0))
    dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  regfile_sb #(.WIDTH(16), .DEPTH(8), .RD_PORTS(3), .TAP_REG(1),
               .BYPASS(1'b1), .ZERO_REG0(1'b1))
    dut_c (.clk(clk), .reset(reset), .bus(c_if.slave));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of instance-A stimulus together with the outputs it must produce.
  typedef struct {
    logic       cr;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       ie;
    logic [1:0] ia;
    logic [1:0] ra0;
    logic [1:0] ra1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] busy;
    logic       pany;
    logic [7:0] tap;
    logic       cbusy;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[12];

  function automatic vec_t mk(input int cr, we, wa, wd, ie, ia, ra0, ra1,
                              d0, d1, busy, pany, tap, cbusy);
    vec_t v;
    v.cr = 1'(cr);   v.we = 1'(we);   v.wa = 2'(wa);     v.wd = 8'(wd);
    v.ie = 1'(ie);   v.ia = 2'(ia);   v.ra0 = 2'(ra0);   v.ra1 = 2'(ra1);
    v.d0 = 8'(d0);   v.d1 = 8'(d1);   v.busy = 2'(busy); v.pany = 1'(pany);
    v.tap = 8'(tap); v.cbusy = 1'(cbusy);
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Drive instance A and queue the outputs expected for this cycle.
  task automatic applyStimulus(input vec_t v);
    a_if.clear_req  = v.cr;
    a_if.wr_en      = v.we;
    a_if.wr_addr    = v.wa;
    a_if.wr_data    = v.wd;
    a_if.issue_en   = v.ie;
    a_if.issue_addr = v.ia;
    a_if.rd_addr    = {v.ra1, v.ra0};
    sb.push_back(v);
  endtask

  // Pop the oldest expectation and compare every instance-A output.
  task automatic checkOutput(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      check_count++;
      $display("[TB] FAIL %s scoreboard empty actual=0 required=1", tag);
    end else begin
      e = sb.pop_front();
      checkVal({tag, " rd_data0"},    32'(a_if.rd_data[7:0]),  32'(e.d0));
      checkVal({tag, " rd_data1"},    32'(a_if.rd_data[15:8]), 32'(e.d1));
      checkVal({tag, " rd_busy"},     32'(a_if.rd_busy),       32'(e.busy));
      checkVal({tag, " pending_any"}, 32'(a_if.pending_any),   32'(e.pany));
      checkVal({tag, " tap_data"},    32'(a_if.tap_data),      32'(e.tap));
      checkVal({tag, " clear_busy"},  32'(a_if.clear_busy),    32'(e.cbusy));
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    applyStimulus(v);
    #2;
    checkOutput(tag);
  endtask

  task automatic idleA();
    a_if.clear_req = 1'b0; a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0;
    a_if.issue_en = 1'b0; a_if.issue_addr = '0; a_if.rd_addr = '0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    reset = 1'b1;
    idleA();
    b_if.clear_req = 1'b0; b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0;
    b_if.issue_en = 1'b0; b_if.issue_addr = '0; b_if.rd_addr = '0;
    c_if.clear_req = 1'b0; c_if.wr_en = 1'b0; c_if.wr_addr = '0; c_if.wr_data = '0;
    c_if.issue_en = 1'b0; c_if.issue_addr = '0; c_if.rd_addr = '0;

    // Vector table: cr we wa wd ie ia ra0 ra1 | d0 d1 busy pany tap cbusy
    vecs[0]  = mk(0,1,2,'hA5,0,0, 2,1, 'hA5,'h00,0,0,'h00,0);
    vecs[1]  = mk(0,1,1,'h3C,0,0, 2,1, 'hA5,'h3C,0,0,'h00,0);
    vecs[2]  = mk(0,0,0,'h00,0,0, 2,1, 'hA5,'h3C,0,0,'h3C,0);
    vecs[3]  = mk(0,1,3,'h77,0,0, 3,0, 'h77,'h00,0,0,'h3C,0);
    vecs[4]  = mk(0,0,0,'h00,1,2, 2,3, 'hA5,'h77,0,0,'h3C,0);
    vecs[5]  = mk(0,0,0,'h00,0,0, 2,3, 'hA5,'h77,1,1,'h3C,0);
    vecs[6]  = mk(0,1,2,'h11,0,0, 2,3, 'h11,'h77,0,1,'h3C,0);
    vecs[7]  = mk(0,0,0,'h00,0,0, 2,1, 'h11,'h3C,0,0,'h3C,0);
    vecs[8]  = mk(0,1,1,'h5A,1,1, 1,2, 'h5A,'h11,0,0,'h3C,0);
    vecs[9]  = mk(0,0,0,'h00,0,0, 1,0, 'h5A,'h00,1,1,'h5A,0);
    vecs[10] = mk(0,1,1,'h66,0,0, 0,1, 'h00,'h66,0,1,'h5A,0);
    vecs[11] = mk(0,0,0,'h00,0,0, 1,1, 'h66,'h66,0,0,'h66,0);

    // Reset state, with a write held on A to show bypass is masked in reset.
    step(mk(0,1,0,'h5A,1,0, 0,1, 0,0,0,0,0,0), "reset");
    checkVal("reset B rd_data", 32'(b_if.rd_data), 32'h0);
    checkVal("reset C rd_data", 32'(c_if.rd_data), 32'h0);
    idleA();
    #1 reset = 1'b0;

    // Main write/read/issue behaviour on A.
    for (int i = 0; i < 12; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Instance B: no bypass, so data and busy follow the edge.
    @(negedge clk);
    b_if.wr_en = 1'b1; b_if.wr_addr = 2'd3; b_if.wr_data = 8'h77; b_if.rd_addr = {2'd0, 2'd3};
    #2 checkVal("B old value before edge", 32'(b_if.rd_data[7:0]), 32'h00);
    @(negedge clk);
    b_if.wr_en = 1'b0;
    #2 checkVal("B new value after edge", 32'(b_if.rd_data[7:0]), 32'h77);
    @(negedge clk);
    b_if.issue_en = 1'b1; b_if.issue_addr = 2'd2; b_if.rd_addr = {2'd0, 2'd2};
    @(negedge clk);
    b_if.issue_en = 1'b0; b_if.wr_en = 1'b1; b_if.wr_addr = 2'd2; b_if.wr_data = 8'h11;
    #2;
    checkVal("B busy held during write", 32'(b_if.rd_busy[0]), 32'h1);
    checkVal("B data old during write",  32'(b_if.rd_data[7:0]), 32'h00);
    @(negedge clk);
    b_if.wr_en = 1'b0;
    #2;
    checkVal("B busy cleared after edge", 32'(b_if.rd_busy[0]),   32'h0);
    checkVal("B data after write",        32'(b_if.rd_data[7:0]), 32'h11);
    checkVal("B pending_any after write", 32'(b_if.pending_any),  32'h0);

    // Instance C: r0 hard-wired to zero, three read ports.
    @(negedge clk);
    c_if.wr_en = 1'b1; c_if.wr_addr = 3'd0; c_if.wr_data = 16'hBEEF;
    c_if.rd_addr = {3'd0, 3'd0, 3'd0};
    #2 checkVal("C r0 write not bypassed", 32'(c_if.rd_data[15:0]), 32'h0);
    @(negedge clk);
    c_if.wr_addr = 3'd7; c_if.wr_data = 16'h1234; c_if.issue_en = 1'b1; c_if.issue_addr = 3'd0;
    c_if.rd_addr = {3'd7, 3'd0, 3'd7};
    #2;
    checkVal("C r7 bypass port0", 32'(c_if.rd_data[15:0]),  32'h1234);
    checkVal("C r0 port1 zero",   32'(c_if.rd_data[31:16]), 32'h0);
    @(negedge clk);
    c_if.wr_en = 1'b0; c_if.issue_en = 1'b0; c_if.rd_addr = {3'd7, 3'd7, 3'd7};
    #2;
    checkVal("C r7 port0", 32'(c_if.rd_data[15:0]),  32'h1234);
    checkVal("C r7 port1", 32'(c_if.rd_data[31:16]), 32'h1234);
    checkVal("C r7 port2", 32'(c_if.rd_data[47:32]), 32'h1234);
    c_if.rd_addr = {3'd0, 3'd0, 3'd0};
    #1;
    checkVal("C r0 reads zero",       32'(c_if.rd_data[15:0]), 32'h0);
    checkVal("C r0 never busy",       32'(c_if.rd_busy),       32'h0);
    checkVal("C pending_any r0 issue", 32'(c_if.pending_any),  32'h0);

    // Clear sweep on A: fill with 0xFF and mark all pending, then clear.
    for (int j = 0; j < 4; j++)
      step(mk(0,1,j,'hFF,1,j, j,j, 'hFF,'hFF,0, (j == 0) ? 0 : 1,
              (j < 2) ? 'h66 : 'hFF, 0), $sformatf("fill%0d", j));
    step(mk(1,0,0,0,0,0, 0,3, 'hFF,'hFF,3,1,'hFF,0), "clear_req");
    // Writes/issues and a repeated clear_req during the sweep must be ignored.
    for (int j = 0; j < 4; j++)
      step(mk((j == 1) ? 1 : 0, 1, j, 'h12, 1, 0, j, (j == 0) ? 0 : j - 1,
              'hFF, (j == 0) ? 'hFF : 'h00, (j == 0) ? 3 : 1, 1,
              (j < 2) ? 'hFF : 'h00, 1), $sformatf("clear%0d", j));
    step(mk(0,0,0,0,0,0, 0,1, 0,0,0,0,0,0), "after clear r0r1");
    step(mk(0,0,0,0,0,0, 2,3, 0,0,0,0,0,0), "after clear r2r3");

    // Reset in the middle of a sweep, with data and a pending flag present.
    step(mk(0,1,3,'hAA,1,3, 2,3, 'h00,'hAA,0,0,0,0), "pre r3");
    step(mk(0,1,2,'hBB,0,0, 2,3, 'hBB,'hAA,2,1,0,0), "pre r2");
    step(mk(1,0,0,0,0,0, 2,3, 'hBB,'hAA,2,1,0,0), "mid clear_req");
    step(mk(0,0,0,0,0,0, 2,3, 'hBB,'hAA,2,1,0,1), "mid idx0");
    step(mk(0,0,0,0,0,0, 2,3, 'hBB,'hAA,2,1,0,1), "mid idx1");
    step(mk(0,0,0,0,0,0, 2,3, 'hBB,'hAA,2,1,0,1), "mid idx2");
    reset = 1'b1;
    #1;
    applyStimulus(mk(0,0,0,0,0,0, 2,3, 0,0,0,0,0,0));
    checkOutput("reset mid-clear");
    @(posedge clk);
    #2 reset = 1'b0;
    step(mk(0,1,2,'h42,0,0, 2,3, 'h42,'h00,0,0,0,0), "post-reset write");
    step(mk(0,0,0,0,0,0, 2,3, 'h42,'h00,0,0,0,0), "post-reset read");

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
